fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined CPU: owns the fetch PC register, drives a variable-latency instruction-memory handshake, and loads the IF/ID pipeline register. It sits directly upstream of the next-PC logic. The next-PC logic reads `if_id_pc` and returns the resolved target through `redirect`/`redirect_pc`. The block absorbs hazard stalls, squashes wrong-path fetches on redirect, and flags misaligned fetch addresses.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/if_id_reg.sv | 60 ++++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and reset constants.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DROP  = 2'd2,
    IF_ERR   = 2'd3
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load has priority over clear, otherwise contents hold.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        exc_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        exc_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        exc_q, exc_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    exc_d   = exc_q;
    if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
      exc_d   = exc_i;
    end else if (clear_i) begin
      // Bubble keeps the old PC; only the payload is neutralised.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      exc_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;
  assign exc_o   = exc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, variable-latency imem handshake, redirect squash and
// misaligned-fetch detection feeding the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        if_id_exc_o
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic        req;
  logic [31:0] addr;
  logic        load;
  logic        clear;
  logic [31:0] load_pc;
  logic [31:0] load_instr;
  logic        load_exc;
  logic        accept;

  assign accept = !stall_i || !if_id_valid_o;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    drop_addr_d = drop_addr_q;
    req         = 1'b0;
    addr        = pc_q;
    load        = 1'b0;
    load_pc     = pc_q;
    load_instr  = imem_rdata_i;
    load_exc    = 1'b0;

    unique case (state_q)
      IF_FETCH: begin
        if (pc_q[1:0] == 2'b00) begin
          req = 1'b1;
          if (imem_ack_i) begin
            if (accept) begin
              load = 1'b1;
              pc_d = pc_q + 32'd4;
            end else begin
              hold_d  = imem_rdata_i;
              state_d = IF_HOLD;
            end
          end
        end else if (accept) begin
          load       = 1'b1;
          load_instr = NOP_INSTR;
          load_exc   = 1'b1;
          state_d    = IF_ERR;
        end
      end
      IF_HOLD: begin
        if (!stall_i) begin
          load       = 1'b1;
          load_instr = hold_q;
          pc_d       = pc_q + 32'd4;
          state_d    = IF_FETCH;
        end
      end
      IF_DROP: begin
        // Stale request must complete at its original address before the target is fetched.
        req  = 1'b1;
        addr = drop_addr_q;
        if (imem_ack_i) begin
          state_d = IF_FETCH;
        end
      end
      IF_ERR: begin
      end
      default: begin
        state_d = IF_FETCH;
      end
    endcase

    if (redirect_i) begin
      load   = 1'b0;
      pc_d   = redirect_pc_i;
      hold_d = NOP_INSTR;
      if (state_q != IF_DROP) begin
        if (req && !imem_ack_i) begin
          state_d     = IF_DROP;
          drop_addr_d = addr;
        end else begin
          state_d = IF_FETCH;
        end
      end
    end

    clear = redirect_i || (!stall_i && !load);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IF_FETCH;
      pc_q        <= RESET_PC;
      hold_q      <= NOP_INSTR;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // Reset abandons any outstanding request without waiting for a clock edge.
  assign imem_req_o  = req & ~rst_i;
  assign imem_addr_o = addr;
  assign pc_o        = pc_q;

  if_id_reg u_if_id_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .clear_i (clear),
    .pc_i    (load_pc),
    .instr_i (load_instr),
    .exc_i   (load_exc),
    .pc_o    (if_id_pc_o),
    .instr_o (if_id_instr_o),
    .valid_o (if_id_valid_o),
    .exc_o   (if_id_exc_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a bench-driven instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        if_id_exc;

  logic        auto_ack;
  logic        man_ack;

  int n_assert;
  int n_fail;

  localparam logic [31:0] Tag = 32'hDEAD_0000;

  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = imem_addr ^ Tag;

  fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .pc_o          (pc),
    .if_id_pc_o    (if_id_pc),
    .if_id_instr_o (if_id_instr),
    .if_id_valid_o (if_id_valid),
    .if_id_exc_o   (if_id_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    auto_ack    = 1'b1;
    man_ack     = 1'b0;

    #1;
    chk("rst_pc",       pc,                   32'h3000);
    chk("rst_addr",     imem_addr,            32'h3000);
    chk("rst_req",      {31'd0, imem_req},    32'd0);
    chk("rst_ifid_pc",  if_id_pc,             32'h0);
    chk("rst_ifid_ins", if_id_instr,          32'h0);
    chk("rst_valid",    {31'd0, if_id_valid}, 32'd0);
    chk("rst_exc",      {31'd0, if_id_exc},   32'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_req",  {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr,         32'h3000);

    // Zero-wait streaming
    tick;
    chk("s0_pc",    if_id_pc,             32'h3000);
    chk("s0_ins",   if_id_instr,          32'h3000 ^ Tag);
    chk("s0_valid", {31'd0, if_id_valid}, 32'd1);
    chk("s0_fpc",   pc,                   32'h3004);
    tick;
    chk("s1_pc",    if_id_pc,             32'h3004);
    chk("s1_ins",   if_id_instr,          32'h3004 ^ Tag);
    tick;
    chk("s2_pc",    if_id_pc,             32'h3008);
    chk("s2_valid", {31'd0, if_id_valid}, 32'd1);

    // Ack at 0x300C coinciding with a 2-cycle stall
    stall = 1'b1;
    tick;
    chk("h0_ifid_pc", if_id_pc,          32'h3008);
    chk("h0_fpc",     pc,                32'h300C);
    chk("h0_req",     {31'd0, imem_req}, 32'd0);
    tick;
    chk("h1_ifid_pc", if_id_pc,          32'h3008);
    chk("h1_req",     {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick;
    chk("h2_ifid_pc", if_id_pc,             32'h300C);
    chk("h2_ins",     if_id_instr,          32'h300C ^ Tag);
    chk("h2_valid",   {31'd0, if_id_valid}, 32'd1);
    chk("h2_fpc",     pc,                   32'h3010);

    // Redirect while 0x3010 is waiting for ack
    auto_ack = 1'b0;
    #1;
    chk("w0_req",  {31'd0, imem_req}, 32'd1);
    chk("w0_addr", imem_addr,         32'h3010);
    tick;
    chk("w1_bubble", {31'd0, if_id_valid}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h3100;
    tick;
    redirect = 1'b0;
    #1;
    chk("d0_fpc",  pc,                32'h3100);
    chk("d0_req",  {31'd0, imem_req}, 32'd1);
    chk("d0_addr", imem_addr,         32'h3010);
    tick;
    chk("d1_addr", imem_addr, 32'h3010);
    man_ack = 1'b1;
    tick;
    man_ack = 1'b0;
    #1;
    chk("d2_valid", {31'd0, if_id_valid}, 32'd0);
    chk("d2_req",   {31'd0, imem_req},    32'd1);
    chk("d2_addr",  imem_addr,            32'h3100);
    auto_ack = 1'b1;
    tick;
    chk("d3_ifid_pc", if_id_pc,             32'h3100);
    chk("d3_ins",     if_id_instr,          32'h3100 ^ Tag);
    chk("d3_valid",   {31'd0, if_id_valid}, 32'd1);

    // Redirect in the same cycle as the ack for 0x3104
    redirect    = 1'b1;
    redirect_pc = 32'h3300;
    tick;
    redirect = 1'b0;
    #1;
    chk("r0_valid", {31'd0, if_id_valid}, 32'd0);
    chk("r0_fpc",   pc,                   32'h3300);
    chk("r0_addr",  imem_addr,            32'h3300);
    chk("r0_req",   {31'd0, imem_req},    32'd1);
    tick;
    chk("r1_ifid_pc", if_id_pc, 32'h3300);

    // Misaligned redirect target
    redirect    = 1'b1;
    redirect_pc = 32'h3102;
    tick;
    redirect = 1'b0;
    #1;
    chk("m0_req", {31'd0, imem_req}, 32'd0);
    tick;
    chk("m1_ifid_pc", if_id_pc,             32'h3102);
    chk("m1_ins",     if_id_instr,          32'h0);
    chk("m1_valid",   {31'd0, if_id_valid}, 32'd1);
    chk("m1_exc",     {31'd0, if_id_exc},   32'd1);
    tick;
    chk("m2_req",   {31'd0, imem_req},    32'd0);
    chk("m2_valid", {31'd0, if_id_valid}, 32'd0);
    tick;
    chk("m3_req", {31'd0, imem_req}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h3200;
    tick;
    redirect = 1'b0;
    #1;
    chk("m4_fpc",  pc,                32'h3200);
    chk("m4_req",  {31'd0, imem_req}, 32'd1);
    chk("m4_addr", imem_addr,         32'h3200);
    tick;
    chk("m5_ifid_pc", if_id_pc,           32'h3200);
    chk("m5_exc",     {31'd0, if_id_exc}, 32'd0);

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect = 1'b0;
    tick;
    chk("wrap_ifid_pc", if_id_pc,           32'hFFFF_FFFC);
    chk("wrap_fpc",     pc,                 32'h0);
    chk("wrap_exc",     {31'd0, if_id_exc}, 32'd0);

    // Reset pulsed while 0x3010 waits for ack
    redirect    = 1'b1;
    redirect_pc = 32'h3010;
    tick;
    redirect = 1'b0;
    auto_ack = 1'b0;
    #1;
    chk("x0_req",  {31'd0, imem_req}, 32'd1);
    chk("x0_addr", imem_addr,         32'h3010);
    tick;
    rst = 1'b1;
    #1;
    chk("x1_req",     {31'd0, imem_req},    32'd0);
    chk("x1_fpc",     pc,                   32'h3000);
    chk("x1_addr",    imem_addr,            32'h3000);
    chk("x1_ifid_pc", if_id_pc,             32'h0);
    chk("x1_valid",   {31'd0, if_id_valid}, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    auto_ack = 1'b1;
    #1;
    chk("x2_req",  {31'd0, imem_req}, 32'd1);
    chk("x2_addr", imem_addr,         32'h3000);
    tick;
    chk("x3_ifid_pc", if_id_pc,             32'h3000);
    chk("x3_valid",   {31'd0, if_id_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
